// File: rtl/maxpool_group_sched_if.sv
// rtl/maxpool_group_sched_if.sv - control, buffer and pool handshake bundle for maxpool_group_sched
interface maxpool_group_sched_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              pause;
  logic              busy;
  logic              done;
  logic              err;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              pool_rst;
  logic              pool_valid_in;
  logic              pool_valid_out;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;

  modport master (
    output start, pause, pool_valid_out,
    input  busy, done, err, rd_en, rd_addr, pool_rst, pool_valid_in, wr_en, wr_addr
  );

  modport slave (
    input  start, pause, pool_valid_out,
    output busy, done, err, rd_en, rd_addr, pool_rst, pool_valid_in, wr_en, wr_addr
  );
endinterface

// File: rtl/maxpool_group_sched.sv
// rtl/maxpool_group_sched.sv - group sequencer for the 4-lane 3x3 max-pool block
// MAXPOOL_SCHED_PERF_EN adds cycle_cnt/stall_cnt performance counters
module maxpool_group_sched #(
  parameter int IMG_Width  = 5,
  parameter int IMG_Height = 5,
  parameter int Channels   = 8,
  parameter int Stride     = 2,
  parameter int ADDR_W     = 8,
  parameter int Timeout    = 64
) (
  input  logic clk,
  input  logic rst,
  maxpool_group_sched_if.slave bus
`ifdef MAXPOOL_SCHED_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [15:0] stall_cnt
`endif
);
  localparam int PIX     = IMG_Width * IMG_Height;
  localparam int OUT_W   = (IMG_Width - 3) / Stride + 1;
  localparam int OUT_H   = (IMG_Height - 3) / Stride + 1;
  localparam int OUT_PIX = OUT_W * OUT_H;
  localparam int GROUPS  = Channels / 4;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_NEXT, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] group, group_nxt;
  logic [31:0] pix, pix_nxt;
  logic [31:0] out_cnt, out_nxt;
  logic [31:0] idle_cnt, idle_nxt;
  logic        err_q, err_nxt;
  logic        pvi_q;
  logic        rd_en_c, wr_en_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      group    <= '0;
      pix      <= '0;
      out_cnt  <= '0;
      idle_cnt <= '0;
      err_q    <= 1'b0;
      pvi_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      group    <= group_nxt;
      pix      <= pix_nxt;
      out_cnt  <= out_nxt;
      idle_cnt <= idle_nxt;
      err_q    <= err_nxt;
      pvi_q    <= rd_en_c;
    end
  end

  always_comb begin
    state_nxt = state;
    group_nxt = group;
    pix_nxt   = pix;
    out_nxt   = out_cnt;
    idle_nxt  = idle_cnt;
    err_nxt   = err_q;
    rd_en_c   = 1'b0;
    wr_en_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = S_CLEAR;
          group_nxt = '0;
          err_nxt   = 1'b0;
        end
        if (bus.pool_valid_out) err_nxt = 1'b1;
      end
      S_CLEAR: begin
        pix_nxt   = '0;
        out_nxt   = '0;
        idle_nxt  = '0;
        state_nxt = S_FEED;
        if (bus.pool_valid_out) err_nxt = 1'b1;
      end
      S_FEED: begin
        if (!bus.pause) begin
          rd_en_c = 1'b1;
          pix_nxt = pix + 1;
          if (pix == PIX - 1) state_nxt = S_DRAIN;
        end
        // Outputs beyond the expected count mean the pool is out of step with us.
        if (bus.pool_valid_out) begin
          if (out_cnt < OUT_PIX) begin
            wr_en_c = 1'b1;
            out_nxt = out_cnt + 1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (bus.pool_valid_out) begin
          wr_en_c  = 1'b1;
          out_nxt  = out_cnt + 1;
          idle_nxt = '0;
        end else begin
          idle_nxt = idle_cnt + 1;
        end
        if (out_nxt >= OUT_PIX) begin
          state_nxt = S_NEXT;
        end else if (!bus.pool_valid_out && (idle_cnt + 1 >= Timeout)) begin
          err_nxt   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_NEXT: begin
        if (group == GROUPS - 1) begin
          state_nxt = S_DONE;
        end else begin
          group_nxt = group + 1;
          state_nxt = S_CLEAR;
        end
        if (bus.pool_valid_out) err_nxt = 1'b1;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        if (bus.pool_valid_out) err_nxt = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.busy          = (state != S_IDLE);
  assign bus.done          = (state == S_DONE);
  assign bus.err           = err_q;
  assign bus.rd_en         = rd_en_c;
  assign bus.rd_addr       = ADDR_W'(group * PIX + pix);
  assign bus.pool_rst      = (state == S_IDLE) || (state == S_CLEAR);
  assign bus.pool_valid_in = pvi_q;
  assign bus.wr_en         = wr_en_c;
  assign bus.wr_addr       = ADDR_W'(group * OUT_PIX + out_cnt);

`ifdef MAXPOOL_SCHED_PERF_EN
  logic accept;
  assign accept = (state == S_IDLE) && bus.start;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
    end else if (accept) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (state != S_IDLE) cycle_cnt <= cycle_cnt + 32'd1;
      if (state == S_FEED && bus.pause && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_maxpool_group_sched.sv
// tb/tb_maxpool_group_sched.sv - self-checking bench for maxpool_group_sched with a stub pool
module tb_maxpool_group_sched;
  localparam int W    = 5;
  localparam int H    = 5;
  localparam int CH   = 8;
  localparam int ST   = 2;
  localparam int AW   = 8;
  localparam int TO   = 64;
  localparam int PIX  = W * H;
  localparam int OPIX = ((W - 3) / ST + 1) * ((H - 3) / ST + 1);
  localparam int GR   = CH / 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  maxpool_group_sched_if #(.ADDR_W(AW)) bus();
`ifdef MAXPOOL_SCHED_PERF_EN
  logic [31:0] cycle_cnt;
  logic [15:0] stall_cnt;
`endif

  maxpool_group_sched #(
    .IMG_Width(W), .IMG_Height(H), .Channels(CH), .Stride(ST), .ADDR_W(AW), .Timeout(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef MAXPOOL_SCHED_PERF_EN
    ,
    .cycle_cnt(cycle_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Stub pool: one output when a 3x3 window completes, capped per group.
  int   lim[GR];
  int   s_in = 0, s_emit = 0, s_grp = -1;
  logic prev_prst = 1'b1;
  logic spur_req = 1'b0;

  function automatic logic win_done(input int k);
    int r, c;
    r = k / W;
    c = k % W;
    return (r >= 2) && (c >= 2) && ((r - 2) % ST == 0) && ((c - 2) % ST == 0);
  endfunction

  always begin
    logic e;
    @(posedge clk);
    #2;
    if (prev_prst && !bus.pool_rst) s_grp++;
    if (!bus.busy) s_grp = -1;
    prev_prst = bus.pool_rst;
    if (bus.pool_rst) begin
      s_in   = 0;
      s_emit = 0;
    end
    e = 1'b0;
    if (bus.pool_valid_in === 1'b1) begin
      if (win_done(s_in) && s_grp >= 0 && s_grp < GR && s_emit < lim[s_grp]) begin
        e = 1'b1;
        s_emit++;
      end
      s_in++;
    end
    bus.pool_valid_out = e | spur_req;
  end

  // Monitor: collects observed traffic; cleared on request from the main sequence.
  logic [AW-1:0] rd_q[$];
  logic [AW-1:0] wr_q[$];
  int   busy_cyc = 0, done_cnt = 0, clr_cyc = 0, pvi_cnt = 0, pvi_bad = 0;
  int   clr_req = 0, clr_seen = 0;
  logic prev_rd_en = 1'b0;

  always @(negedge clk) begin
    if (clr_req != clr_seen) begin
      clr_seen = clr_req;
      rd_q.delete();
      wr_q.delete();
      busy_cyc = 0; done_cnt = 0; clr_cyc = 0; pvi_cnt = 0; pvi_bad = 0;
    end
    if (!rst) begin
      prev_rd_en = 1'b0;
    end else begin
      if (bus.pool_valid_in !== prev_rd_en) pvi_bad++;
      prev_rd_en = bus.rd_en;
      if (bus.rd_en === 1'b1) rd_q.push_back(bus.rd_addr);
      if (bus.wr_en === 1'b1) wr_q.push_back(bus.wr_addr);
      if (bus.busy === 1'b1) busy_cyc++;
      if (bus.done === 1'b1) done_cnt++;
      if (bus.busy === 1'b1 && bus.pool_rst === 1'b1) clr_cyc++;
      if (bus.pool_valid_in === 1'b1) pvi_cnt++;
    end
  end

  task automatic check_reset(input string tag);
    check({tag, " busy"}, 32'(bus.busy), 0);
    check({tag, " done"}, 32'(bus.done), 0);
    check({tag, " err"}, 32'(bus.err), 0);
    check({tag, " rd_en"}, 32'(bus.rd_en), 0);
    check({tag, " rd_addr"}, 32'(bus.rd_addr), 0);
    check({tag, " pool_rst"}, 32'(bus.pool_rst), 1);
    check({tag, " pool_valid_in"}, 32'(bus.pool_valid_in), 0);
    check({tag, " wr_en"}, 32'(bus.wr_en), 0);
    check({tag, " wr_addr"}, 32'(bus.wr_addr), 0);
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ok = 1;
        break;
      end
    end
    check({tag, " done_seen"}, 32'(ok), 1);
  endtask

  task automatic wait_rd(input string tag, input int addr);
    int ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (bus.rd_en === 1'b1 && bus.rd_addr == AW'(addr)) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check({tag, " rd_sync"}, 32'(ok), 1);
  endtask

  // Layer run; expectations come straight from the layer geometry and stub output caps.
  task automatic run_layer(input string tag, input int pg, input int pp, input int pl,
                           input int l0, input int l1, input logic exp_err);
    logic [AW-1:0] erd[$];
    logic [AW-1:0] ewr[$];
    int exp_busy = 0;
    int groups_run = 0;
    lim[0] = l0;
    lim[1] = l1;
    for (int g = 0; g < GR; g++) begin
      groups_run++;
      for (int p = 0; p < PIX; p++) erd.push_back(AW'(g * PIX + p));
      for (int k = 0; k < OPIX && k < lim[g]; k++) ewr.push_back(AW'(g * OPIX + k));
      exp_busy += 1 + PIX;
      if (lim[g] < OPIX) begin
        exp_busy += TO;
        break;
      end
      exp_busy += 2;
    end
    exp_busy += 1 + pl;

    clr_req++;
    @(negedge clk);
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    if (pl > 0) begin
      wait_rd(tag, pg * PIX + pp);
      bus.pause = 1'b1;
      repeat (pl) begin
        @(posedge clk);
        #1;
      end
      bus.pause = 1'b0;
    end
    wait_done(tag, 400);
    repeat (2) @(negedge clk);

    check({tag, " rd_count"}, 32'(rd_q.size()), 32'(erd.size()));
    for (int i = 0; i < erd.size() && i < rd_q.size(); i++)
      check($sformatf("%s rd[%0d]", tag, i), 32'(rd_q[i]), 32'(erd[i]));
    check({tag, " wr_count"}, 32'(wr_q.size()), 32'(ewr.size()));
    for (int i = 0; i < ewr.size() && i < wr_q.size(); i++)
      check($sformatf("%s wr[%0d]", tag, i), 32'(wr_q[i]), 32'(ewr[i]));
    check({tag, " busy_cycles"}, 32'(busy_cyc), 32'(exp_busy));
    check({tag, " done_pulses"}, 32'(done_cnt), 1);
    check({tag, " clear_cycles"}, 32'(clr_cyc), 32'(groups_run));
    check({tag, " valid_in_count"}, 32'(pvi_cnt), 32'(erd.size()));
    check({tag, " valid_in_delay"}, 32'(pvi_bad), 0);
    check({tag, " err"}, 32'(bus.err), 32'(exp_err));
    check({tag, " busy_after"}, 32'(bus.busy), 0);
`ifdef MAXPOOL_SCHED_PERF_EN
    check({tag, " cycle_cnt"}, cycle_cnt, 32'(exp_busy));
    check({tag, " stall_cnt"}, 32'(stall_cnt), 32'(pl));
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int pg, pp, pl;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    lim[0] = OPIX;
    lim[1] = OPIX;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1 rst = 1'b1;

    run_layer("plain", 0, 0, 0, OPIX, OPIX, 1'b0);
    run_layer("pause10", 0, 10, 3, OPIX, OPIX, 1'b0);
    for (int r = 0; r < 2; r++) begin
      pg = int'($urandom_range(0, GR - 1));
      pp = int'($urandom_range(1, PIX - 2));
      pl = int'($urandom_range(1, 6));
      run_layer($sformatf("rand%0d", r), pg, pp, pl, OPIX, OPIX, 1'b0);
    end

    run_layer("timeout", 0, 0, 0, OPIX, OPIX - 1, 1'b1);
    run_layer("err_clear", 0, 0, 0, OPIX, OPIX, 1'b0);

    @(negedge clk);
    check("spur pre_err", 32'(bus.err), 0);
    @(posedge clk); #1 spur_req = 1'b1;
    @(negedge clk);
    check("spur wr_en", 32'(bus.wr_en), 0);
    @(posedge clk); #1 spur_req = 1'b0;
    @(negedge clk);
    check("spur err", 32'(bus.err), 1);
    run_layer("after_spur", 0, 0, 0, OPIX, OPIX, 1'b0);

    clr_req++;
    @(negedge clk);
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_rd("midrst", PIX + 12);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset("midrst");
    check("midrst done_pulses", 32'(done_cnt), 0);
    @(posedge clk); #1 rst = 1'b1;
    run_layer("after_rst", 0, 0, 0, OPIX, OPIX, 1'b0);

    clr_req++;
    @(negedge clk);
    @(posedge clk); #1 bus.start = 1'b1;
    wait_done("hold", 400);
    check("hold busy_in_done", 32'(bus.busy), 1);
    @(negedge clk);
    check("hold idle_busy", 32'(bus.busy), 0);
    check("hold idle_done", 32'(bus.done), 0);
    check("hold done_pulses", 32'(done_cnt), 1);
    check("hold rd_count", 32'(rd_q.size()), 32'(PIX * GR));
    @(negedge clk);
    check("hold reaccept_busy", 32'(bus.busy), 1);
    check("hold reaccept_pool_rst", 32'(bus.pool_rst), 1);
    @(posedge clk); #1 bus.start = 1'b0;
    wait_done("hold2", 400);
    repeat (2) @(negedge clk);
    check("hold2 done_pulses", 32'(done_cnt), 2);
    check("hold2 rd_count", 32'(rd_q.size()), 32'(2 * PIX * GR));
    check("hold2 err", 32'(bus.err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
